uart_peripheral: RTL and testbench

Memory-mapped UART transceiver on the CPU peripheral bus, alongside the timer/LED/switch/digit peripheral. It decodes its own three word addresses (0x40000018–0x40000020) and returns read data that the bus-side rdata mux ORs with the other peripherals. It serialises bytes the CPU writes and deserialises bytes arriving on `uart_rxd`. It raises `irqout` toward the CPU's interrupt logic on TX completion and/or RX arrival.

---
 rtl/uart_peripheral_if.sv | 31 +++
 rtl/uart_peripheral.sv | 253 +++++++++++++++++++++++++
 tb/tb_uart_peripheral.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_peripheral_if.sv
// uart_peripheral_if
//   Peripheral bus bundle shared by the CPU (master) and memory-mapped peripherals (slave).
//   rd    : read strobe
//   wr    : write strobe
//   addr  : 32-bit byte address
//   wdata : write data
//   rdata : read data from the peripheral. It is combinational, and it is 0 when the
//           peripheral does not own the address.
interface uart_peripheral_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output rd,
        output wr,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  rd,
        input  wr,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/uart_peripheral.sv
// uart_peripheral
//   Memory-mapped 8N1 UART transceiver with a level interrupt.
//   Register map:
//     0x40000018  UART_TXD : write starts a frame when TX is idle; read returns the last accepted byte
//     0x4000001C  UART_RXD : read returns the received byte; a read clears RX_VALID and OVERRUN
//     0x40000020  UART_CON : [0] TX_IRQ_EN, [1] RX_IRQ_EN, [2] TX_DONE, [3] RX_VALID,
//                            [4] TX_BUSY, [5] OVERRUN, [6] FRAME_ERR.
//                            A read clears TX_DONE and FRAME_ERR.
//   Ports:
//     clk      : rising-edge clock
//     reset    : asynchronous, active-low reset
//     bus      : peripheral bus (slave modport)
//     uart_rxd : serial input. It is asynchronous and idles high.
//     uart_txd : serial output. It is registered and idles high.
//     irqout   : (TX_IRQ_EN & TX_DONE) | (RX_IRQ_EN & RX_VALID)
//   Build option: UART_LOOPBACK_EN takes the RX input from uart_txd internally. In that build
//   uart_rxd is ignored.
module uart_peripheral #(
    parameter int unsigned BAUD_DIV = 5208
) (
    input  logic                clk,
    input  logic                reset,
    uart_peripheral_if.slave    bus,
    input  logic                uart_rxd,
    output logic                uart_txd,
    output logic                irqout
);

    localparam logic [31:0] AddrTxd = 32'h4000_0018;
    localparam logic [31:0] AddrRxd = 32'h4000_001C;
    localparam logic [31:0] AddrCon = 32'h4000_0020;

    localparam int unsigned CntW = $clog2(BAUD_DIV);
    localparam logic [CntW-1:0] BaudLast = CntW'(BAUD_DIV - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    // Address decode and bus qualifiers
    logic sel_txd, sel_rxd, sel_con;
    logic rd_rxd, rd_con, wr_con, tx_accept;

    // TX state
    tx_state_e        tx_state_q;
    logic [CntW-1:0]  tx_cnt_q;
    logic [2:0]       tx_bit_q;
    logic [7:0]       tx_byte_q;
    logic             uart_txd_q;
    logic             tx_done_q;
    logic             tx_busy;

    // RX state
    rx_state_e        rx_state_q;
    logic [CntW-1:0]  rx_cnt_q;
    logic [2:0]       rx_bit_q;
    logic [7:0]       rx_shift_q;
    logic [7:0]       rx_byte_q;
    logic             rx_valid_q;
    logic             overrun_q;
    logic             frame_err_q;
    logic [1:0]       rx_sync_q;
    logic             rx_in;
    logic             rx_s;

    // Control bits
    logic             tx_irq_en_q;
    logic             rx_irq_en_q;

    logic [23:0]      unused_wdata;
    assign unused_wdata = bus.wdata[31:8];

    assign sel_txd   = (bus.addr == AddrTxd);
    assign sel_rxd   = (bus.addr == AddrRxd);
    assign sel_con   = (bus.addr == AddrCon);
    assign rd_rxd    = bus.rd & sel_rxd;
    assign rd_con    = bus.rd & sel_con;
    assign wr_con    = bus.wr & sel_con;
    assign tx_accept = bus.wr & sel_txd & (tx_state_q == TxIdle);
    assign tx_busy   = (tx_state_q != TxIdle);

`ifdef UART_LOOPBACK_EN
    logic unused_rxd;
    assign unused_rxd = uart_rxd;
    assign rx_in      = uart_txd_q;
`else
    assign rx_in      = uart_rxd;
`endif

    // Transmitter. uart_txd is registered from the current state, so the line lags the
    // state by one cycle. Each state still lasts exactly BAUD_DIV cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_byte_q  <= '0;
            uart_txd_q <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            if (rd_con) tx_done_q <= 1'b0;

            unique case (tx_state_q)
                TxStart: uart_txd_q <= 1'b0;
                TxData:  uart_txd_q <= tx_byte_q[tx_bit_q];
                default: uart_txd_q <= 1'b1;
            endcase

            unique case (tx_state_q)
                TxIdle: begin
                    if (tx_accept) begin
                        tx_byte_q  <= bus.wdata[7:0];
                        tx_cnt_q   <= '0;
                        tx_state_q <= TxStart;
                    end
                end
                TxStart: begin
                    if (tx_cnt_q == BaudLast) begin
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_state_q <= TxData;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TxData: begin
                    if (tx_cnt_q == BaudLast) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 3'd7) tx_state_q <= TxStop;
                        else                  tx_bit_q   <= tx_bit_q + 1'b1;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TxStop: begin
                    if (tx_cnt_q == BaudLast) begin
                        tx_cnt_q   <= '0;
                        tx_state_q <= TxIdle;
                        tx_done_q  <= 1'b1;   // the set overrides a same-edge read clear
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: tx_state_q <= TxIdle;
            endcase
        end
    end

    // Two-flop synchroniser. Its reset value is the idle level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rx_sync_q <= 2'b11;
        else        rx_sync_q <= {rx_sync_q[0], rx_in};
    end
    assign rx_s = rx_sync_q[1];

    // Receiver. Entering START preloads the counter with 1, so the start-bit re-sample
    // falls BAUD_DIV/2 cycles after the synchronised falling edge. Data bits are then
    // sampled at mid-bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q  <= RxIdle;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (rd_rxd) begin
                rx_valid_q <= 1'b0;
                overrun_q  <= 1'b0;
            end
            if (rd_con) frame_err_q <= 1'b0;

            unique case (rx_state_q)
                RxIdle: begin
                    if (!rx_s) begin
                        rx_cnt_q   <= {{(CntW-1){1'b0}}, 1'b1};
                        rx_state_q <= RxStart;
                    end
                end
                RxStart: begin
                    if (rx_cnt_q == HalfLast) begin
                        rx_cnt_q <= '0;
                        if (rx_s) begin
                            rx_state_q <= RxIdle;   // glitch, not a start bit
                        end else begin
                            rx_bit_q   <= '0;
                            rx_state_q <= RxData;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RxData: begin
                    if (rx_cnt_q == BaudLast) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_s, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) rx_state_q <= RxStop;
                        else                  rx_bit_q   <= rx_bit_q + 1'b1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RxStop: begin
                    if (rx_cnt_q == BaudLast) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RxIdle;
                        if (rx_s) begin
                            rx_byte_q  <= rx_shift_q;
                            rx_valid_q <= 1'b1;
                            if (rx_valid_q) overrun_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= RxIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_irq_en_q <= 1'b0;
            rx_irq_en_q <= 1'b0;
        end else if (wr_con) begin
            tx_irq_en_q <= bus.wdata[0];
            rx_irq_en_q <= bus.wdata[1];
        end
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.rd) begin
            if (sel_txd) begin
                bus.rdata = {24'b0, tx_byte_q};
            end else if (sel_rxd) begin
                bus.rdata = {24'b0, rx_byte_q};
            end else if (sel_con) begin
                bus.rdata = {25'b0, frame_err_q, overrun_q, tx_busy, rx_valid_q,
                             tx_done_q, rx_irq_en_q, tx_irq_en_q};
            end
        end
    end

    assign uart_txd = uart_txd_q;
    assign irqout   = (tx_irq_en_q & tx_done_q) | (rx_irq_en_q & rx_valid_q);

endmodule

// File: tb/tb_uart_peripheral.sv
// tb_uart_peripheral
//   Directed bench for uart_peripheral at BAUD_DIV=16. Inputs change on the falling clock
//   edge and outputs are sampled on the falling edge, away from the active edge.
module tb_uart_peripheral;

    localparam int unsigned B = 16;
    localparam logic [31:0] ATXD = 32'h4000_0018;
    localparam logic [31:0] ARXD = 32'h4000_001C;
    localparam logic [31:0] ACON = 32'h4000_0020;

`ifdef UART_LOOPBACK_EN
    // In loopback the RX flags follow our own TX traffic, so they are left out of CON compares.
    localparam logic [31:0] CON_MASK = 32'hFFFF_FF97;
`else
    localparam logic [31:0] CON_MASK = 32'hFFFF_FFFF;
`endif

    logic clk;
    logic reset;
    logic uart_rxd;
    logic uart_txd;
    logic irqout;

    int n_asserts;
    int n_fail;

    uart_peripheral_if bus ();

    uart_peripheral #(
        .BAUD_DIV(B)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .uart_rxd (uart_rxd),
        .uart_txd (uart_txd),
        .irqout   (irqout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // All bus tasks are called on a falling edge and return on the next falling edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.wr    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        @(negedge clk);
        bus.wr    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus.rd   = 1'b1;
        bus.addr = a;
        #1 d = bus.rdata;
        @(negedge clk);
        bus.rd   = 1'b0;
        bus.addr = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic [31:0] m;
        m = (a == ACON) ? CON_MASK : 32'hFFFF_FFFF;
        bus_read(a, d);
        check(tag, d & m, exp & m);
    endtask

    // 8N1 frame on uart_rxd. When good is 0, the stop bit is held low for 10 cycles and then
    // released, so the mid-bit sample sees 0.
    task automatic send_byte(input logic [7:0] b, input bit good);
        uart_rxd = 1'b0;
        wait_neg(B);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            wait_neg(B);
        end
        if (good) begin
            uart_rxd = 1'b1;
            wait_neg(B);
        end else begin
            uart_rxd = 1'b0;
            wait_neg(10);
            uart_rxd = 1'b1;
            wait_neg(B - 10);
        end
        uart_rxd = 1'b1;
    endtask

    initial begin
        logic [9:0] frame;
        n_asserts = 0;
        n_fail    = 0;
        reset     = 1'b0;
        uart_rxd  = 1'b1;
        bus.rd    = 1'b0;
        bus.wr    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;

        // Reset state
        @(negedge clk);
        check("rst_txd", {31'b0, uart_txd}, 32'd1);
        check("rst_irq", {31'b0, irqout}, 32'd0);
        rd_chk("rst_con", ACON, 32'h0);
        reset = 1'b1;
        wait_neg(2);
        rd_chk("rst_txd_reg", ATXD, 32'h0);
        rd_chk("rst_rxd_reg", ARXD, 32'h0);

        // Decode: rdata is 0 without rd, and 0 for addresses the UART does not own
        bus.addr = ACON;
        #1 check("rdata_no_rd", bus.rdata, 32'h0);
        bus.addr = '0;
        @(negedge clk);
        rd_chk("unowned_24", 32'h4000_0024, 32'h0);
        rd_chk("unowned_14", 32'h4000_0014, 32'h0);
        rd_chk("unowned_hi", 32'hC000_0018, 32'h0);

        // TX frame 0xA5. The write edge E lies half a cycle before bus_write returns.
        frame = {1'b1, 8'hA5, 1'b0};
        bus_write(ATXD, 32'h0000_00A5);
        check("tx_pre_fall", {31'b0, uart_txd}, 32'd1);
        wait_neg(1);
        check("tx_fall", {31'b0, uart_txd}, 32'd0);
        wait_neg(7);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) wait_neg(B);
            check($sformatf("tx_a5_bit%0d", k), {31'b0, uart_txd}, {31'b0, frame[k]});
        end
        wait_neg(7);
        // The last cycle of STOP is still busy. TX_DONE sets on this read's edge, and the set wins.
        rd_chk("tx_con_busy_end", ACON, 32'h10);
        rd_chk("tx_con_done", ACON, 32'h04);
        check("tx_irq_dis", {31'b0, irqout}, 32'd0);
        rd_chk("tx_con_cleared", ACON, 32'h00);

        // A write while busy is dropped, and so is a write on the edge TX returns to idle
        bus_write(ACON, 32'h1);
        frame = {1'b1, 8'h55, 1'b0};
        bus_write(ATXD, 32'h0000_0055);
        rd_chk("busy_con", ACON, 32'h11);
        bus_write(ATXD, 32'h0000_0066);
        rd_chk("busy_txd_reg", ATXD, 32'h55);
        wait_neg(6);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) wait_neg(B);
            check($sformatf("tx_55_bit%0d", k), {31'b0, uart_txd}, {31'b0, frame[k]});
        end
        wait_neg(6);
        check("busy_irq_pre", {31'b0, irqout}, 32'd0);
        bus_write(ATXD, 32'h0000_0066);
        check("busy_irq_done", {31'b0, irqout}, 32'd1);
        wait_neg(20);
        check("busy_no_2nd", {31'b0, uart_txd}, 32'd1);
        rd_chk("busy_txd_reg2", ATXD, 32'h55);
        rd_chk("busy_con_done", ACON, 32'h05);
        rd_chk("busy_con_clr", ACON, 32'h01);
        check("busy_irq_clr", {31'b0, irqout}, 32'd0);
`ifdef UART_LOOPBACK_EN
        rd_chk("loop_rxd", ARXD, 32'h55);
`endif

`ifndef UART_LOOPBACK_EN
        // RX 0x3C. RX_VALID, and with it irqout, rises exactly 2 + B/2 + 9B cycles after the fall.
        bus_write(ACON, 32'h2);
        fork
            send_byte(8'h3C, 1'b1);
            begin
                wait_neg(2 + B / 2 + 9 * B - 1);
                check("rx_irq_before", {31'b0, irqout}, 32'd0);
                wait_neg(1);
                check("rx_irq_at", {31'b0, irqout}, 32'd1);
            end
        join
        rd_chk("rx_con_valid", ACON, 32'h0A);
        rd_chk("rx_data", ARXD, 32'h3C);
        rd_chk("rx_con_after", ACON, 32'h02);
        check("rx_irq_clr", {31'b0, irqout}, 32'd0);

        // Overrun: two back-to-back frames with no read in between
        bus_write(ACON, 32'h0);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        wait_neg(10);
        rd_chk("ovr_con", ACON, 32'h28);
        rd_chk("ovr_data", ARXD, 32'h22);
        rd_chk("ovr_con_after", ACON, 32'h00);

        // A framing error keeps RX_VALID and the previous byte
        send_byte(8'h77, 1'b1);
        send_byte(8'h12, 1'b0);
        wait_neg(20);
        rd_chk("ferr_con", ACON, 32'h48);
        rd_chk("ferr_data", ARXD, 32'h77);
        rd_chk("ferr_con_after", ACON, 32'h00);

        // A 3-cycle low glitch is rejected
        uart_rxd = 1'b0;
        wait_neg(3);
        uart_rxd = 1'b1;
        wait_neg(40);
        rd_chk("glitch_con", ACON, 32'h00);
        rd_chk("glitch_data", ARXD, 32'h77);
`endif

        // Reset in the middle of a TX frame
        bus_write(ACON, 32'h3);
        bus_write(ATXD, 32'h0000_00F0);
        wait_neg(30);
        check("mid_txd_low", {31'b0, uart_txd}, 32'd0);
        reset = 1'b0;
        #1;
        check("mid_rst_txd", {31'b0, uart_txd}, 32'd1);
        check("mid_rst_irq", {31'b0, irqout}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        rd_chk("mid_rst_con", ACON, 32'h00);
        rd_chk("mid_rst_txd_reg", ATXD, 32'h00);
        wait_neg(20);
        check("mid_rst_idle", {31'b0, uart_txd}, 32'd1);
        check("mid_rst_irq2", {31'b0, irqout}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
